// File: rtl/exec_seq_pkg.sv
// Shared execution-state definitions for the decoder and the execution sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package exec_seq_pkg;

    // Execution states; WD is the W$ state of the original machine.
    typedef enum logic [3:0] {
        IDLE, PP, WE, WA, WP, WR, WM, WW, WX, WZ, WD, FP, KC
    } exec_state_t;

    // Width of the one-hot state bus seen by the decoder (IDLE and KC have no bit).
    localparam int unsigned ST_W  = 11;

    // Bit positions of each state inside the one-hot state bus.
    localparam int unsigned OH_PP = 0;
    localparam int unsigned OH_WE = 1;
    localparam int unsigned OH_WA = 2;
    localparam int unsigned OH_WP = 3;
    localparam int unsigned OH_WR = 4;
    localparam int unsigned OH_WM = 5;
    localparam int unsigned OH_WW = 6;
    localparam int unsigned OH_WX = 7;
    localparam int unsigned OH_WZ = 8;
    localparam int unsigned OH_WD = 9;
    localparam int unsigned OH_FP = 10;

    function automatic logic [ST_W-1:0] state_onehot(input exec_state_t s);
        logic [ST_W-1:0] oh;
        oh = '0;
        case (s)
            PP:      oh[OH_PP] = 1'b1;
            WE:      oh[OH_WE] = 1'b1;
            WA:      oh[OH_WA] = 1'b1;
            WP:      oh[OH_WP] = 1'b1;
            WR:      oh[OH_WR] = 1'b1;
            WM:      oh[OH_WM] = 1'b1;
            WW:      oh[OH_WW] = 1'b1;
            WX:      oh[OH_WX] = 1'b1;
            WZ:      oh[OH_WZ] = 1'b1;
            WD:      oh[OH_WD] = 1'b1;
            FP:      oh[OH_FP] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

    // States that run the STROB1/STROB2 phase sequence.
    function automatic logic is_strobed(input exec_state_t s);
        return !(s inside {IDLE, FP, KC});
    endfunction

    // States that perform a bus transfer and wait for mem_ok.
    function automatic logic is_mem(input exec_state_t s);
        return s inside {WR, WW, WM};
    endfunction

endpackage

// File: rtl/exec_seq_phase_timer.sv
// Phase timer: STROB1 -> optional memory wait -> STROB2, plus bus request and timeout.
// Latency: restart takes effect next cycle; strobes and mem_req are flop outputs.
// Backpressure: the wait phase holds until mem_ok; tmo_o fires after MEM_TMO wait cycles.
module exec_seq_phase_timer
    import exec_seq_pkg::*;
#(
    parameter int unsigned S1_CYC  = 2,
    parameter int unsigned S2_CYC  = 2,
    parameter int unsigned MEM_TMO = 255,
    parameter int unsigned CW      = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    input  logic mem_i,
    input  logic stop_i,
    input  logic mem_ok_i,
    output logic strob1_o,
    output logic strob2_o,
    output logic mem_req_o,
    output logic done_s2_o,
    output logic tmo_o
);

    localparam logic [CW-1:0] S1_LAST  = CW'(S1_CYC - 1);
    localparam logic [CW-1:0] S2_LAST  = CW'(S2_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TMO - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    logic          s1_q, s1_d;
    logic          wt_q, wt_d;
    logic          s2_q, s2_d;
    logic          req_q, req_d;
    logic          ok_q, ok_d;      // transfer acknowledged (always set for non-memory states)
    logic [CW-1:0] cnt_q, cnt_d;    // cycles spent in the current phase, saturating
    logic          done_s1;
    logic          got_ok;

    assign done_s1   = s1_q && (cnt_q == S1_LAST);
    assign done_s2_o = s2_q && (cnt_q == S2_LAST);
    // mem_ok in the final wait cycle still wins over the alarm.
    assign tmo_o     = wt_q && !mem_ok_i && (cnt_q >= TMO_LAST);
    assign got_ok    = ok_q | (req_q & mem_ok_i);

    assign strob1_o  = s1_q;
    assign strob2_o  = s2_q;
    assign mem_req_o = req_q;

    // Phase sequencing: restart begins STROB1, stop parks the timer, otherwise advance phases.
    always_comb begin
        s1_d  = s1_q;
        wt_d  = wt_q;
        s2_d  = s2_q;
        req_d = req_q;
        ok_d  = ok_q;
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        if (restart_i) begin
            s1_d  = 1'b1;
            wt_d  = 1'b0;
            s2_d  = 1'b0;
            req_d = mem_i;
            ok_d  = !mem_i;
            cnt_d = '0;
        end else if (stop_i) begin
            s1_d  = 1'b0;
            wt_d  = 1'b0;
            s2_d  = 1'b0;
            req_d = 1'b0;
            ok_d  = 1'b0;
            cnt_d = '0;
        end else begin
            // A reply drops the request at once and is remembered for the end of STROB1.
            if (req_q && mem_ok_i) begin
                req_d = 1'b0;
                ok_d  = 1'b1;
            end
            if (done_s1) begin
                s1_d  = 1'b0;
                cnt_d = '0;
                if (got_ok) begin
                    s2_d = 1'b1;
                end else begin
                    wt_d = 1'b1;
                end
            end else if (wt_q && mem_ok_i) begin
                wt_d  = 1'b0;
                s2_d  = 1'b1;
                cnt_d = '0;
            end
        end
    end

    // Phase registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q  <= 1'b0;
            wt_q  <= 1'b0;
            s2_q  <= 1'b0;
            req_q <= 1'b0;
            ok_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            wt_q  <= wt_d;
            s2_q  <= s2_d;
            req_q <= req_d;
            ok_q  <= ok_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exec_seq.sv
// Execution-phase sequencer: one-hot exec state, STROB1/STROB2 timing, memory handshake.
// Latency: all outputs registered; a request sampled on the last STROB2 cycle acts next cycle.
// Backpressure: memory states stall in a wait phase until mem_ok or the MEM_TMO alarm.
module exec_seq
    import exec_seq_pkg::*;
#(
    parameter int unsigned S1_CYC  = 2,
    parameter int unsigned S2_CYC  = 2,
    parameter int unsigned MEM_TMO = 255
) (
    input  logic clk_sys_i,
    input  logic clr_n_i,
    input  logic start_i,
    input  logic ewa_i,
    input  logic ewe_i,
    input  logic ewp_i,
    input  logic ewr_i,
    input  logic ewm_i,
    input  logic eww_i,
    input  logic ewx_i,
    input  logic ewz_i,
    input  logic ewd_i,
    input  logic efp_i,
    input  logic ekc_1_i,
    input  logic ekc_2_i,
    input  logic mem_ok_i,
    input  logic fp_done_i,
    output logic pp_o,
    output logic we_o,
    output logic wa_o,
    output logic wp_o,
    output logic wr_o,
    output logic wm_o,
    output logic ww_o,
    output logic wx_o,
    output logic wz_o,
    output logic wd_o,
    output logic fp_o,
    output logic strob1_o,
    output logic strob2_o,
    output logic mem_req_o,
    output logic kc_o,
    output logic alm_nomem_o,
    output logic seq_err_o
);

    localparam int unsigned S_MAX = (S1_CYC > S2_CYC) ? S1_CYC : S2_CYC;
    localparam int unsigned T_MAX = (S_MAX > MEM_TMO) ? S_MAX : MEM_TMO;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    exec_state_t     state_q, state_d, req_state;
    logic [ST_W-1:0] oh_q;
    logic            kc_q;
    logic            alm_q, alm_d;
    logic            err_q, err_d;
    logic [10:0]     req_vec;
    logic            req_one;
    logic            done_s2;
    logic            tmo;
    logic            restart;
    logic            stop;

    // Priority encoder over the decoder's enter-state requests (ekc_1|ekc_2 is one request).
    always_comb begin
        req_vec   = {ekc_1_i | ekc_2_i, efp_i, ewr_i, eww_i, ewm_i,
                     ewa_i, ewe_i, ewp_i, ewx_i, ewz_i, ewd_i};
        req_one   = $onehot(req_vec);
        req_state = KC;
        if      (req_vec[10]) req_state = KC;
        else if (efp_i)       req_state = FP;
        else if (ewr_i)       req_state = WR;
        else if (eww_i)       req_state = WW;
        else if (ewm_i)       req_state = WM;
        else if (ewa_i)       req_state = WA;
        else if (ewe_i)       req_state = WE;
        else if (ewp_i)       req_state = WP;
        else if (ewx_i)       req_state = WX;
        else if (ewz_i)       req_state = WZ;
        else if (ewd_i)       req_state = WD;
    end

    // Next-state and sticky flag logic.
    always_comb begin
        state_d = state_q;
        alm_d   = alm_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = PP;
                    alm_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            FP: begin
                if (fp_done_i) state_d = KC;
            end
            KC: begin
                state_d = IDLE;
            end
            default: begin
                if (tmo) begin
                    state_d = KC;
                    alm_d   = 1'b1;
                end else if (done_s2) begin
                    state_d = req_state;
                    if (!req_one) err_d = 1'b1;
                end
            end
        endcase
    end

    // Re-entering the same state still restarts the phase timer.
    assign restart = is_strobed(state_d) && ((state_d != state_q) || done_s2);
    assign stop    = !is_strobed(state_d);

    exec_seq_phase_timer #(
        .S1_CYC  (S1_CYC),
        .S2_CYC  (S2_CYC),
        .MEM_TMO (MEM_TMO),
        .CW      (CW)
    ) u_timer (
        .clk_i     (clk_sys_i),
        .rst_n_i   (clr_n_i),
        .restart_i (restart),
        .mem_i     (is_mem(state_d)),
        .stop_i    (stop),
        .mem_ok_i  (mem_ok_i),
        .strob1_o  (strob1_o),
        .strob2_o  (strob2_o),
        .mem_req_o (mem_req_o),
        .done_s2_o (done_s2),
        .tmo_o     (tmo)
    );

    // State register with registered one-hot and kc outputs.
    always_ff @(posedge clk_sys_i) begin
        if (!clr_n_i) begin
            state_q <= IDLE;
            oh_q    <= '0;
            kc_q    <= 1'b0;
            alm_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            oh_q    <= state_onehot(state_d);
            kc_q    <= (state_d == KC);
            alm_q   <= alm_d;
            err_q   <= err_d;
        end
    end

    assign pp_o        = oh_q[OH_PP];
    assign we_o        = oh_q[OH_WE];
    assign wa_o        = oh_q[OH_WA];
    assign wp_o        = oh_q[OH_WP];
    assign wr_o        = oh_q[OH_WR];
    assign wm_o        = oh_q[OH_WM];
    assign ww_o        = oh_q[OH_WW];
    assign wx_o        = oh_q[OH_WX];
    assign wz_o        = oh_q[OH_WZ];
    assign wd_o        = oh_q[OH_WD];
    assign fp_o        = oh_q[OH_FP];
    assign kc_o        = kc_q;
    assign alm_nomem_o = alm_q;
    assign seq_err_o   = err_q;

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: instruction plans expand into per-cycle stimulus/expectation traces.
// Latency: outputs compared 1 time unit after each clock edge.
// Backpressure: mem_ok/fp_done latencies come from the plan, including timeouts.
module tb_exec_seq;

    localparam int S1  = 2;
    localparam int S2  = 2;
    localparam int TMO = 8;

    // Bench state codes; the one-hot output bit of code c is bit c.
    localparam int C_PP = 0, C_WE = 1, C_WA = 2, C_WP = 3, C_WR = 4, C_WM = 5;
    localparam int C_WW = 6, C_WX = 7, C_WZ = 8, C_WD = 9, C_FP = 10, C_KC = 11, C_IDLE = 12;

    // req[c] asks for state c (1..10), req[11]/req[12] are ekc_1/ekc_2.
    typedef struct packed {
        logic        rst;
        logic        start;
        logic [12:0] req;
        logic        mem_ok;
        logic        fp_done;
    } stim_t;

    typedef struct packed {
        logic [10:0] oh;
        logic        s1;
        logic        s2;
        logic        mreq;
        logic        kc;
        logic        alm;
        logic        err;
    } obs_t;

    // One visited state: how it is left (req) and its mem_ok / fp_done cycle index (lat).
    typedef struct packed {
        logic [12:0] req;
        logic [7:0]  lat;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_n, start, ewa, ewe, ewp, ewr, ewm, eww, ewx, ewz, ewd, efp, ekc_1, ekc_2;
    logic mem_ok, fp_done;
    logic pp, we, wa, wp, wr, wm, ww, wx, wz, wd, fp, strob1, strob2, mem_req, kc, alm, serr;

    exec_seq #(.S1_CYC(S1), .S2_CYC(S2), .MEM_TMO(TMO)) dut (
        .clk_sys_i(clk), .clr_n_i(clr_n), .start_i(start),
        .ewa_i(ewa), .ewe_i(ewe), .ewp_i(ewp), .ewr_i(ewr), .ewm_i(ewm), .eww_i(eww),
        .ewx_i(ewx), .ewz_i(ewz), .ewd_i(ewd), .efp_i(efp), .ekc_1_i(ekc_1), .ekc_2_i(ekc_2),
        .mem_ok_i(mem_ok), .fp_done_i(fp_done),
        .pp_o(pp), .we_o(we), .wa_o(wa), .wp_o(wp), .wr_o(wr), .wm_o(wm), .ww_o(ww),
        .wx_o(wx), .wz_o(wz), .wd_o(wd), .fp_o(fp), .strob1_o(strob1), .strob2_o(strob2),
        .mem_req_o(mem_req), .kc_o(kc), .alm_nomem_o(alm), .seq_err_o(serr)
    );

    int    ntests = 0;
    int    nfail  = 0;
    logic  cur_alm = 1'b0;
    logic  cur_err = 1'b0;
    stim_t sq[$];
    obs_t  eq[$];
    step_t plan[$];

    function automatic obs_t sample();
        obs_t o;
        o.oh   = {fp, wd, wz, wx, ww, wm, wr, wp, wa, we, pp};
        o.s1   = strob1;
        o.s2   = strob2;
        o.mreq = mem_req;
        o.kc   = kc;
        o.alm  = alm;
        o.err  = serr;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        clr_n   = !s.rst;
        start   = s.start;
        ewe     = s.req[1];
        ewa     = s.req[2];
        ewp     = s.req[3];
        ewr     = s.req[4];
        ewm     = s.req[5];
        eww     = s.req[6];
        ewx     = s.req[7];
        ewz     = s.req[8];
        ewd     = s.req[9];
        efp     = s.req[10];
        ekc_1   = s.req[11];
        ekc_2   = s.req[12];
        mem_ok  = s.mem_ok;
        fp_done = s.fp_done;
    endtask

    function automatic logic [12:0] rq(input int c);
        return 13'(1) << c;
    endfunction

    function automatic step_t stp(input logic [12:0] r, input int l);
        step_t t;
        t.req = r;
        t.lat = 8'(l);
        return t;
    endfunction

    function automatic obs_t mk(input int code, input logic s1, input logic s2,
                                input logic mreq, input logic k);
        obs_t e;
        e = '0;
        if (code <= C_FP) e.oh = 11'(1) << code;
        e.s1   = s1;
        e.s2   = s2;
        e.mreq = mreq;
        e.kc   = k;
        e.alm  = cur_alm;
        e.err  = cur_err;
        return e;
    endfunction

    // Inputs that must be ignored at this point: stray requests and starts.
    function automatic stim_t noise();
        stim_t s;
        s = '0;
        s.start = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) s.req = 13'($urandom) & 13'h1FFE;
        return s;
    endfunction

    // Decoder priority: KC > FP > WR > WW > WM > WA > WE > WP > WX > WZ > W$; none -> KC.
    function automatic int pick(input logic [12:0] r);
        int order[10];
        order = '{C_FP, C_WR, C_WW, C_WM, C_WA, C_WE, C_WP, C_WX, C_WZ, C_WD};
        if (r[11] | r[12]) return C_KC;
        for (int i = 0; i < 10; i++) if (r[order[i]]) return order[i];
        return C_KC;
    endfunction

    task automatic push(input stim_t s, input obs_t e);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic build_start(input int idle_n);
        stim_t s;
        for (int i = 0; i < idle_n; i++) begin
            s = noise();
            s.start = 1'b0;
            push(s, mk(C_IDLE, 0, 0, 0, 0));
        end
        s = noise();
        s.start = 1'b1;
        push(s, mk(C_IDLE, 0, 0, 0, 0));
        cur_alm = 1'b0;
        cur_err = 1'b0;
    endtask

    task automatic emit_strobed(input int code, input int lat, input logic [12:0] r, output int nxt);
        stim_t s;
        logic  mem, tmo;
        int    wt, n1, total, nreq;
        mem   = (code == C_WR) || (code == C_WW) || (code == C_WM);
        tmo   = mem && (lat >= S1 + TMO);
        wt    = !mem ? 0 : tmo ? TMO : (lat < S1) ? 0 : lat - S1 + 1;
        n1    = S1 + wt;
        total = tmo ? n1 : n1 + S2;
        for (int i = 0; i < total; i++) begin
            s = noise();
            s.mem_ok = mem && !tmo && (i == lat);
            if (!tmo && i == total - 1) s.req = r;
            push(s, mk(code, i < S1, i >= n1, mem && (i <= lat), 0));
        end
        if (tmo) begin
            cur_alm = 1'b1;
            nxt = C_KC;
        end else begin
            nreq = int'(r[11] | r[12]) + $countones(r[10:1]);
            if (nreq != 1) cur_err = 1'b1;
            nxt = pick(r);
        end
    endtask

    task automatic run_plan();
        step_t st;
        stim_t s;
        int    code, nxt, k;
        code = C_PP;
        k = 0;
        while (code != C_KC) begin
            st = '0;
            if (k < plan.size()) st = plan[k];
            k++;
            if (code == C_FP) begin
                for (int i = 0; i <= int'(st.lat); i++) begin
                    s = noise();
                    s.fp_done = (i == int'(st.lat));
                    push(s, mk(C_FP, 0, 0, 0, 0));
                end
                code = C_KC;
            end else begin
                emit_strobed(code, int'(st.lat), st.req, nxt);
                code = nxt;
            end
        end
        s = noise();
        push(s, mk(C_KC, 0, 0, 0, 1));
    endtask

    task automatic play(input string tag);
        obs_t o;
        for (int c = 0; c < sq.size(); c++) begin
            o = sample();
            ntests++;
            assert (o === eq[c]) else begin
                nfail++;
                $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, o, eq[c]);
            end
            drive(sq[c]);
            @(posedge clk);
            #1;
        end
        sq.delete();
        eq.delete();
    endtask

    task automatic instr(input int idle_n, input string tag);
        build_start(idle_n);
        run_plan();
        play(tag);
    endtask

    // PP -> WM, then reset during the memory wait: IDLE next cycle, no kc.
    task automatic build_abort();
        stim_t s;
        int    nxt;
        build_start(1);
        emit_strobed(C_PP, 0, rq(C_WM), nxt);
        for (int i = 0; i < S1 + 3; i++) begin
            s = noise();
            s.rst = (i == S1 + 2);
            push(s, mk(C_WM, i < S1, 0, 1, 0));
        end
        cur_alm = 1'b0;
        cur_err = 1'b0;
        s = '0;
        push(s, mk(C_IDLE, 0, 0, 0, 0));
    endtask

    initial begin
        stim_t rs;
        logic [12:0] r;
        int n;
        rs = '0;
        rs.rst = 1'b1;
        drive(rs);
        repeat (3) @(posedge clk);
        #1;
        ntests++;
        assert (sample() === obs_t'('0)) else begin
            nfail++;
            $error("FAIL reset_state: observed %h expected 0", sample());
        end

        plan.delete(); plan.push_back(stp(rq(C_WA), 0)); plan.push_back(stp(rq(12), 0));
        instr(0, "pp_wa_kc");
        plan.delete(); plan.push_back(stp(rq(C_WR), 0)); plan.push_back(stp(rq(11), 4));
        instr(1, "wr_mem_ok");
        plan.delete(); plan.push_back(stp(rq(C_WW), 0)); plan.push_back(stp('0, 99));
        instr(1, "ww_timeout");
        plan.delete(); plan.push_back(stp(rq(C_WA) | rq(C_WR), 0)); plan.push_back(stp(rq(11), 0));
        instr(0, "multi_req");
        plan.delete(); plan.push_back(stp('0, 0));
        instr(2, "no_req");
        plan.delete(); plan.push_back(stp(rq(C_FP), 0)); plan.push_back(stp('0, 9));
        instr(0, "fp_wait");
        plan.delete(); plan.push_back(stp(rq(C_FP), 0)); plan.push_back(stp('0, 0));
        instr(0, "fp_done_entry");
        plan.delete(); plan.push_back(stp(rq(C_WE), 0)); plan.push_back(stp(rq(C_WE), 0));
        plan.push_back(stp(rq(12), 0));
        instr(0, "reentry");
        plan.delete(); plan.push_back(stp(rq(C_WM), 0)); plan.push_back(stp(rq(12), 1));
        instr(0, "mem_ok_in_s1");
        plan.delete(); plan.push_back(stp(rq(C_WW), 0)); plan.push_back(stp(rq(11), S1 + TMO - 1));
        instr(0, "mem_ok_last_wait");
        build_abort();
        play("abort_wm");
        plan.delete(); plan.push_back(stp(rq(C_WA), 0)); plan.push_back(stp(rq(12), 0));
        instr(0, "after_abort");

        for (int t = 0; t < 80; t++) begin
            plan.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 9))
                    0:       r = '0;
                    1, 2:    r = 13'($urandom) & 13'h1FFE;
                    3:       r = rq($urandom_range(11, 12));
                    default: r = rq($urandom_range(1, 10));
                endcase
                plan.push_back(stp(r, $urandom_range(0, 11)));
            end
            instr($urandom_range(0, 2), "random");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
